player_action_tx: RTL and testbench

- Downstream of the client keyboard stage.
- Takes the 3-bit player action code (0 = none, 1..4 = move) and serialises it onto a single wire to the host game board.
- Uses a fixed 6-bit frame (start, 3 data, even parity, stop). A frame is sent whenever the action differs from the last one transmitted.
- Lets the host track the current key state with one pin and no handshake back.

---
 rtl/player_link_pkg.sv | 46 ++++
 rtl/player_action_tx_baud_tick.sv | 31 +++
 rtl/player_action_tx.sv | 159 +++++++++++++++
 tb/tb_player_action_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/player_link_pkg.sv
// Shared definitions for the player action serial link.
// The host-side receiver imports this same package, so action codes,
// frame size and state encodings must stay in step on both ends.
package player_link_pkg;

  // Width of an action code. ACT_W is taken by the "W" action below,
  // so the width uses the longer name ACT_WIDTH.
  localparam int ACT_WIDTH = 3;

  // Action codes from the keyboard stage.
  localparam logic [ACT_WIDTH-1:0] ACT_NONE = 3'd0;
  localparam logic [ACT_WIDTH-1:0] ACT_W    = 3'd1;
  localparam logic [ACT_WIDTH-1:0] ACT_S    = 3'd2;
  localparam logic [ACT_WIDTH-1:0] ACT_UP   = 3'd3;
  localparam logic [ACT_WIDTH-1:0] ACT_DOWN = 3'd4;

  // Frame layout: start, three data bits LSB first, even parity, stop.
  localparam int FRAME_BITS = 6;
  localparam int DATA_BITS  = 3;

  // State encodings, shared so the receiver can decode debug taps.
  localparam logic [2:0] ST_ENC_IDLE   = 3'd0;
  localparam logic [2:0] ST_ENC_START  = 3'd1;
  localparam logic [2:0] ST_ENC_DATA   = 3'd2;
  localparam logic [2:0] ST_ENC_PARITY = 3'd3;
  localparam logic [2:0] ST_ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_ENC_IDLE,
    ST_START  = ST_ENC_START,
    ST_DATA   = ST_ENC_DATA,
    ST_PARITY = ST_ENC_PARITY,
    ST_STOP   = ST_ENC_STOP
  } link_state_t;

  // Codes above ACT_DOWN are not real actions and collapse to ACT_NONE.
  function automatic logic [ACT_WIDTH-1:0] sanitize_action(input logic [ACT_WIDTH-1:0] a);
    return (a > ACT_DOWN) ? ACT_NONE : a;
  endfunction

  // Even parity over the data bits.
  function automatic logic even_parity(input logic [ACT_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/player_action_tx_baud_tick.sv
// Serial bit timer: counts 0..CLK_DIV-1 and flags the last cycle of
// each bit period. Held at zero while clear is high so that the first
// bit of a frame always gets a full period.
module baud_tick #(
  parameter int CLK_DIV = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tc
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_LAST);

  // Free-running bit counter, wraps on terminal count, parked by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_action_tx.sv
// Player action transmitter: sends a 6-bit frame (start, d0..d2, even
// parity, stop) on a single idle-high wire whenever the sanitised
// action differs from the last one sent.
// Optional feature: define KEEPALIVE_EN to re-send the last action after
// KEEPALIVE_CYC idle cycles so the host can recover from a lost frame.
module player_action_tx
  import player_link_pkg::*;
#(
  parameter int CLK_DIV       = 10416,
  parameter int KEEPALIVE_CYC = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ACT_WIDTH-1:0] action,
  output logic                 tx,
  output logic                 busy,
  output logic [ACT_WIDTH-1:0] last_sent
);

  link_state_t          state;
  link_state_t          state_n;
  logic [1:0]           bit_idx;
  logic [1:0]           bit_idx_n;
  logic [ACT_WIDTH-1:0] act_q;
  logic [ACT_WIDTH-1:0] data_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 tx_n;
  logic                 start_frame;
  logic                 bit_tc;
  logic                 ka_fire;

  assign tx   = tx_q;
  assign busy = (state != ST_IDLE);

  baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == ST_IDLE),
    .tc    (bit_tc)
  );

  // Register the sanitised action once; the FSM only ever looks at act_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= ACT_NONE;
    end else begin
      act_q <= sanitize_action(action);
    end
  end

`ifdef KEEPALIVE_EN
  localparam int KA_W = (KEEPALIVE_CYC > 1) ? $clog2(KEEPALIVE_CYC) : 1;
  localparam logic [KA_W-1:0] KA_LAST = KA_W'(KEEPALIVE_CYC - 1);

  logic [KA_W-1:0] ka_cnt;

  assign ka_fire = (state == ST_IDLE) && (ka_cnt == KA_LAST) && (act_q == last_sent);

  // Idle-cycle counter; any frame start, change-driven or keepalive, restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka_cnt <= '0;
    end else if (start_frame) begin
      ka_cnt <= '0;
    end else if (state == ST_IDLE) begin
      ka_cnt <= ka_cnt + KA_W'(1);
    end
  end
`else
  logic ka_unused;

  assign ka_fire   = 1'b0;
  assign ka_unused = (KEEPALIVE_CYC > 0);
`endif

  // Next-state logic and the line level that goes with the next state.
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    start_frame = 1'b0;
    tx_n        = 1'b1;

    case (state)
      ST_IDLE: begin
        if ((act_q != last_sent) || ka_fire) begin
          start_frame = 1'b1;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        if (bit_tc) begin
          state_n   = ST_DATA;
          bit_idx_n = 2'd0;
        end
      end
      ST_DATA: begin
        if (bit_tc) begin
          if (bit_idx == 2'(DATA_BITS - 1)) begin
            state_n = ST_PARITY;
          end else begin
            bit_idx_n = bit_idx + 2'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tc) begin
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tc) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_IDLE:   tx_n = 1'b1;
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = data_q[bit_idx_n];
      ST_PARITY: tx_n = parity_q;
      ST_STOP:   tx_n = 1'b1;
      default:   tx_n = 1'b1;
    endcase
  end

  // State, bit index and registered line output; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_idx <= 2'd0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      tx_q    <= tx_n;
    end
  end

  // Capture the frame payload at start; it stays frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= ACT_NONE;
      parity_q  <= 1'b0;
      last_sent <= ACT_NONE;
    end else if (start_frame) begin
      data_q    <= act_q;
      parity_q  <= even_parity(act_q);
      last_sent <= act_q;
    end
  end

endmodule

// File: tb/tb_player_action_tx.sv
// Testbench for player_action_tx with CLK_DIV=4, KEEPALIVE_CYC=50.
// A frame-level reference model predicts tx, busy and last_sent every cycle.
module tb_player_action_tx;

  localparam int CLK_DIV       = 4;
  localparam int KEEPALIVE_CYC = 50;
  localparam int FRAME_CYC     = 6 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] action = 3'd0;
  logic       tx;
  logic       busy;
  logic [2:0] last_sent;

  int check_count = 0;
  int fail_count  = 0;

  player_action_tx #(
    .CLK_DIV       (CLK_DIV),
    .KEEPALIVE_CYC (KEEPALIVE_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .action    (action),
    .tx        (tx),
    .busy      (busy),
    .last_sent (last_sent)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a position counter over 6*CLK_DIV cycles.
  int         m_pos  = 0;
  bit         m_busy = 0;
  logic [2:0] m_actq = 3'd0;
  logic [2:0] m_last = 3'd0;
  logic [2:0] m_data = 3'd0;
  int         m_idle = 0;

  function automatic logic expected_tx();
    int slot;
    if (!m_busy) return 1'b1;
    slot = m_pos / CLK_DIV;
    case (slot)
      0:       return 1'b0;
      1:       return m_data[0];
      2:       return m_data[1];
      3:       return m_data[2];
      4:       return m_data[0] ^ m_data[1] ^ m_data[2];
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  = 0;
      m_busy = 0;
      m_actq = 3'd0;
      m_last = 3'd0;
      m_data = 3'd0;
      m_idle = 0;
    end else begin
      bit start;
      if (m_busy) begin
        m_pos = m_pos + 1;
        if (m_pos == FRAME_CYC) m_busy = 0;
      end else begin
        start = (m_actq != m_last);
`ifdef KEEPALIVE_EN
        if (m_idle == KEEPALIVE_CYC - 1) start = 1;
`endif
        if (start) begin
          m_busy = 1;
          m_pos  = 0;
          m_last = m_actq;
          m_data = m_actq;
          m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
      m_actq = (action >= 3'd5) ? 3'd0 : action;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("tx", 32'(tx), 32'(expected_tx()));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("last_sent", 32'(last_sent), 32'(m_last));
  end

  // Drive an action just after a rising edge and hold it for n cycles.
  task automatic applyStimulus(input logic [2:0] act, input int n);
    action = act;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Async reset pulse with an immediate check that the line goes idle.
  task automatic applyReset(input logic [2:0] act_after);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_sent", 32'(last_sent), 32'd0);
    action = act_after;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    applyStimulus(3'd0, 100);

    $display("[TB] single frame of 3");
    applyStimulus(3'd3, 40);

    $display("[TB] changes during a frame");
    applyStimulus(3'd1, 7);
    applyStimulus(3'd2, 5);
    applyStimulus(3'd4, 60);

    $display("[TB] out-of-range codes");
    applyStimulus(3'd6, 40);
    applyStimulus(3'd7, 40);
    applyStimulus(3'd2, 40);
    applyStimulus(3'd6, 40);

    $display("[TB] reset mid-frame");
    applyStimulus(3'd1, 11);
    applyReset(3'd3);
    applyStimulus(3'd3, 40);

    $display("[TB] back-to-back toggling");
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 3'd1 : 3'd2, FRAME_CYC + 1);
    end

    $display("[TB] randomized actions");
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        applyStimulus(3'($urandom_range(0, 4)), $urandom_range(2, 20));
        applyReset(3'($urandom_range(0, 7)));
      end else begin
        applyStimulus(3'($urandom_range(0, 7)), $urandom_range(1, 35));
      end
    end

    $display("[TB] held action");
    applyStimulus(3'd4, 200);
    applyStimulus(3'd0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
